// File: rtl/button_conditioner.sv
// button_conditioner
//   Input stage in front of the ship controller. Each raw button passes
//   through a two-flop synchroniser and a stability-counter debouncer.
//   The debounced left/right levels drive a press-and-hold repeat FSM that
//   emits one-cycle move ticks (enable). The debounced fire level is
//   edge-detected into a one-shot fire_pulse. Every output is a flop.

module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 360000,
  parameter int unsigned REPEAT_DELAY    = 10800000,
  parameter int unsigned REPEAT_PERIOD   = 3600000,
  parameter int unsigned CNT_W           = 24
) (
  input  logic clk_36MHz,
  input  logic reset,
  input  logic left_raw,
  input  logic right_raw,
  input  logic fire_raw,
  output logic left_debounced,
  output logic right_debounced,
  output logic fire_debounced,
  output logic enable,
  output logic fire_pulse
);

  // Terminal counts. A counter that holds value LIMIT on a clock edge
  // completes its interval on that edge.
  localparam logic [CNT_W-1:0] DEB_LIMIT = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LIMIT  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LIMIT  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Channel order used by every 3-bit vector below: {fire, right, left}.
  localparam int CH_LEFT  = 0;
  localparam int CH_RIGHT = 1;
  localparam int CH_FIRE  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_t;

  logic [2:0]       w_raw;
  logic [2:0]       r_sync1;
  logic [2:0]       r_sync2;
  logic [2:0]       w_db;

  rep_state_t       r_fsm;
  rep_state_t       w_next_fsm;
  logic [CNT_W-1:0] r_rcnt;
  logic [CNT_W-1:0] w_next_rcnt;
  logic             r_last_dir;
  logic             w_next_last_dir;
  logic             w_tick;
  logic             w_dir_active;
  logic             w_dir;
  logic [CNT_W-1:0] w_limit;

  logic             r_enable;
  logic             r_fire_prev;
  logic             r_fire_pulse;

  assign w_raw = {fire_raw, right_raw, left_raw};

  // Two-flop synchroniser for all three asynchronous buttons.
  always_ff @(posedge clk_36MHz) begin
    if (reset) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // One debouncer per channel: the level only follows the synchronised
  // input after it has disagreed with the level for DEBOUNCE_CYCLES edges
  // in a row; any agreement restarts the count.
  for (genvar g = 0; g < 3; g++) begin : g_deb
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;

    // Stability counter and debounced level for this channel.
    always_ff @(posedge clk_36MHz) begin
      if (reset) begin
        r_cnt   <= CNT_ZERO;
        r_level <= 1'b0;
      end else if (r_sync2[g] == r_level) begin
        r_cnt   <= CNT_ZERO;
      end else if (r_cnt == DEB_LIMIT) begin
        r_cnt   <= CNT_ZERO;
        r_level <= ~r_level;
      end else begin
        r_cnt   <= r_cnt + CNT_ONE;
      end
    end

    assign w_db[g] = r_level;
  end

  // Exactly one of left/right held means motion; right selects direction.
  assign w_dir_active = w_db[CH_LEFT] ^ w_db[CH_RIGHT];
  assign w_dir        = w_db[CH_RIGHT];
  assign w_limit      = (r_fsm == ST_REPEAT) ? RP_LIMIT : RD_LIMIT;

  // Repeat FSM state, shared interval counter and latched direction.
  always_ff @(posedge clk_36MHz) begin
    if (reset) begin
      r_fsm      <= ST_IDLE;
      r_rcnt     <= CNT_ZERO;
      r_last_dir <= 1'b0;
    end else begin
      r_fsm      <= w_next_fsm;
      r_rcnt     <= w_next_rcnt;
      r_last_dir <= w_next_last_dir;
    end
  end

  // Next-state logic: a fresh press (or a direction swap) ticks at once and
  // starts the long delay; afterwards ticks come every repeat period.
  always_comb begin
    w_next_fsm      = r_fsm;
    w_next_rcnt     = r_rcnt;
    w_next_last_dir = r_last_dir;
    w_tick          = 1'b0;
    case (r_fsm)
      ST_IDLE: begin
        if (w_dir_active) begin
          w_tick          = 1'b1;
          w_next_last_dir = w_dir;
          w_next_rcnt     = CNT_ZERO;
          w_next_fsm      = ST_DELAY;
        end else begin
          w_next_rcnt     = CNT_ZERO;
        end
      end
      ST_DELAY, ST_REPEAT: begin
        if (!w_dir_active) begin
          w_next_rcnt     = CNT_ZERO;
          w_next_fsm      = ST_IDLE;
        end else if (w_dir != r_last_dir) begin
          // A swap restarts the press; it absorbs any tick due this cycle.
          w_tick          = 1'b1;
          w_next_last_dir = w_dir;
          w_next_rcnt     = CNT_ZERO;
          w_next_fsm      = ST_DELAY;
        end else if (r_rcnt == w_limit) begin
          w_tick          = 1'b1;
          w_next_rcnt     = CNT_ZERO;
          w_next_fsm      = ST_REPEAT;
        end else begin
          w_next_rcnt     = r_rcnt + CNT_ONE;
        end
      end
      default: begin
        w_next_rcnt       = CNT_ZERO;
        w_next_fsm        = ST_IDLE;
      end
    endcase
  end

  // Registered move tick.
  always_ff @(posedge clk_36MHz) begin
    if (reset) begin
      r_enable <= 1'b0;
    end else begin
      r_enable <= w_tick;
    end
  end

  // One-shot fire pulse on the cycle after the debounced level rises.
  always_ff @(posedge clk_36MHz) begin
    if (reset) begin
      r_fire_prev  <= 1'b0;
      r_fire_pulse <= 1'b0;
    end else begin
      r_fire_prev  <= w_db[CH_FIRE];
      r_fire_pulse <= w_db[CH_FIRE] & ~r_fire_prev;
    end
  end

  assign left_debounced  = w_db[CH_LEFT];
  assign right_debounced = w_db[CH_RIGHT];
  assign fire_debounced  = w_db[CH_FIRE];
  assign enable          = r_enable;
  assign fire_pulse      = r_fire_pulse;

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner
//   Stimulus process drives one cycle at a time, steps a behavioural model
//   and queues the expected outputs; a monitor pops and compares after each
//   clock edge. Directed scenarios also check the absolute tick cycles.

module tb_button_conditioner;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;

  logic clk = 1'b0;
  logic reset;
  logic left_raw, right_raw, fire_raw;
  logic left_db, right_db, fire_db, enable, fire_pulse;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0] v;   // {left, right, fire, enable, fire_pulse}
    int         k;   // clock edges since reset release (0 during reset)
  } exp_t;

  exp_t sb[$];
  int   en_log[$];
  int   fp_log[$];
  exp_t mon_e;
  logic [4:0] mon_act;

  // Model state
  logic [2:0] m_p1, m_p2, m_db, m_db_prev;
  logic [2:0] win[$];
  int         kk;
  bit         m_active;
  logic       m_dir;
  int         m_start;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .CNT_W          (24)
  ) dut (
    .clk_36MHz      (clk),
    .reset          (reset),
    .left_raw       (left_raw),
    .right_raw      (right_raw),
    .fire_raw       (fire_raw),
    .left_debounced (left_db),
    .right_debounced(right_db),
    .fire_debounced (fire_db),
    .enable         (enable),
    .fire_pulse     (fire_pulse)
  );

  always #5 clk = ~clk;

  // Monitor: compare DUT outputs against the queued expectation.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e   = sb.pop_front();
      mon_act = {left_db, right_db, fire_db, enable, fire_pulse};
      total++;
      if (mon_act !== mon_e.v) begin
        bad++;
        $display("FAIL outputs k=%0d got=%b want=%b (left,right,fire,enable,fire_pulse)",
                 mon_e.k, mon_act, mon_e.v);
      end
      if (enable === 1'b1) en_log.push_back(mon_e.k);
      if (fire_pulse === 1'b1) fp_log.push_back(mon_e.k);
    end
  end

  // One clock of stimulus plus the reference model for that clock edge.
  // raw = {fire, right, left}
  task automatic cyc(input logic r, input logic [2:0] raw);
    logic [2:0] old;
    logic       tick, fp, all_diff;
    int         el;
    exp_t       e;
    @(negedge clk);
    reset     = r;
    left_raw  = raw[0];
    right_raw = raw[1];
    fire_raw  = raw[2];
    if (r) begin
      m_p1 = 3'b000; m_p2 = 3'b000; m_db = 3'b000; m_db_prev = 3'b000;
      win.delete();
      kk = 0;
      m_active = 1'b0;
      e.v = 5'b00000;
      e.k = 0;
    end else begin
      kk++;
      old  = m_db;
      tick = 1'b0;
      // Move ticks: first tick at press start, then after RD, then every RP.
      if ((old[0] ^ old[1]) == 1'b0) begin
        m_active = 1'b0;
      end else if (!m_active || old[1] != m_dir) begin
        m_active = 1'b1;
        m_start  = kk;
        m_dir    = old[1];
        tick     = 1'b1;
      end else begin
        el   = kk - m_start;
        tick = (el == RD) || (el > RD && ((el - RD) % RP) == 0);
      end
      fp = old[2] & ~m_db_prev[2];
      // Level flips once the input, seen two cycles late, has disagreed
      // for the last DEB samples.
      win.push_back(m_p2);
      if (win.size() > DEB) void'(win.pop_front());
      if (win.size() == DEB) begin
        for (int c = 0; c < 3; c++) begin
          all_diff = 1'b1;
          foreach (win[i]) if (win[i][c] == old[c]) all_diff = 1'b0;
          if (all_diff) m_db[c] = ~old[c];
        end
      end
      m_db_prev = old;
      m_p2 = m_p1;
      m_p1 = raw;
      e.v = {m_db[0], m_db[1], m_db[2], tick, fp};
      e.k = kk;
    end
    sb.push_back(e);
  endtask

  // Let the monitor consume the last queued cycle without skipping a clock.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_log(input string nm, input int got[$], input string want);
    string s;
    s = "";
    foreach (got[i]) s = {s, $sformatf("%0d ", got[i])};
    total++;
    if (s != want) begin
      bad++;
      $display("FAIL %s got=[%s] want=[%s]", nm, s, want);
    end
  endtask

  task automatic clear_logs();
    en_log.delete();
    fp_log.delete();
  endtask

  logic [2:0] rnd_raw;
  int         hold[3];
  logic       rnd_rst;

  initial begin
    reset = 1'b1; left_raw = 1'b0; right_raw = 1'b0; fire_raw = 1'b0;

    // Buttons held through reset; left and fire stay held afterwards.
    repeat (3) cyc(1'b1, 3'b111);
    repeat (80) cyc(1'b0, 3'b101);
    repeat (20) cyc(1'b0, 3'b000);
    settle();
    check_log("hold_left_ticks", en_log, "7 27 35 43 51 59 67 75 83 ");
    check_log("fire_one_shot", fp_log, "7 ");
    clear_logs();

    // Bouncing left: toggles every 2 cycles, never long enough to count.
    repeat (3) cyc(1'b1, 3'b000);
    for (int i = 0; i < 40; i++) cyc(1'b0, {2'b00, 1'((i / 2) % 2)});
    repeat (10) cyc(1'b0, 3'b000);
    settle();
    check_log("bounce_no_tick", en_log, "");
    clear_logs();

    // Both held, then right dropped.
    repeat (3) cyc(1'b1, 3'b000);
    repeat (30) cyc(1'b0, 3'b011);
    repeat (30) cyc(1'b0, 3'b001);
    repeat (15) cyc(1'b0, 3'b000);
    settle();
    check_log("both_then_left", en_log, "37 57 65 ");
    clear_logs();

    // Reset while auto-repeating.
    repeat (3) cyc(1'b1, 3'b000);
    repeat (45) cyc(1'b0, 3'b001);
    repeat (2) cyc(1'b1, 3'b001);
    repeat (30) cyc(1'b0, 3'b001);
    repeat (15) cyc(1'b0, 3'b000);
    settle();
    check_log("reset_mid_repeat", en_log, "7 27 35 43 7 27 35 ");
    clear_logs();

    // Random hold lengths, short glitches, direction swaps, stray resets.
    rnd_raw = 3'b000;
    for (int c = 0; c < 3; c++) hold[c] = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < 3; c++) begin
        if (hold[c] == 0) begin
          rnd_raw[c] = 1'($urandom_range(1, 0));
          if ($urandom_range(3, 0) == 0) hold[c] = int'($urandom_range(3, 1));
          else                           hold[c] = int'($urandom_range(60, 4));
        end
        hold[c]--;
      end
      rnd_rst = ($urandom_range(499, 0) == 0);
      cyc(rnd_rst, rnd_raw);
    end
    repeat (10) cyc(1'b0, 3'b000);
    settle();

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
